// File: rtl/calc_operand_entry.sv
// Keypad operand-entry controller: turns debounced key levels into BCD operands
// and hands NOPS committed operands to the ALU sequencer, one pulse per operand.
module calc_operand_entry #(
    parameter int NDIGITS     = 4,
    parameter int NOPS        = 2,
    parameter int AUTO_COMMIT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 key_pressed,
    input  logic [3:0]           key_code,
    output logic                 busy,
    output logic [4*NDIGITS-1:0] display,
    output logic [3:0]           digit_count,
    output logic [1:0]           op_index,
    output logic                 op_valid,
    output logic [4*NDIGITS-1:0] op_value,
    output logic                 done,
    output logic                 overflow_err
);

    localparam int DW = 4 * NDIGITS;
    localparam logic [3:0] ND_C      = 4'(NDIGITS);
    localparam logic [3:0] ND_LAST_C = 4'(NDIGITS - 1);
    localparam logic [1:0] OP_LAST_C = 2'(NOPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic            key_prev_r;
    logic [DW-1:0]   display_r, display_s;
    logic [3:0]      count_r, count_s;
    logic [1:0]      op_index_r, op_index_s;
    logic [DW-1:0]   op_value_r, op_value_s;
    logic            op_valid_r, op_valid_s;
    logic            done_r, done_s;
    logic            overflow_r, overflow_s;
    logic            busy_r;
    logic            event_s;
    logic [DW-1:0]   shifted_s;

    assign event_s = key_pressed & ~key_prev_r;

    // A single-digit operand has no older digits to keep when shifting in.
    if (NDIGITS == 1) begin : g_shift_one
        assign shifted_s = key_code;
    end else begin : g_shift_many
        assign shifted_s = {display_r[DW-5:0], key_code};
    end

    // Next-state and next-register computation for the entry sequencer.
    always_comb begin
        state_s    = state_r;
        display_s  = display_r;
        count_s    = count_r;
        op_index_s = op_index_r;
        op_value_s = op_value_r;
        op_valid_s = 1'b0;
        done_s     = 1'b0;
        overflow_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_ENTRY;
                    op_index_s = 2'd0;
                    display_s  = '0;
                    count_s    = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ENTRY: begin
                if (!event_s) begin
                    state_s = ST_ENTRY;
                end else if (key_code <= 4'h9) begin
                    if (count_r == ND_C) begin
                        overflow_s = 1'b1;
                    end else if ((count_r == 4'd0) && (key_code == 4'h0)) begin
                        // leading zero keeps the operand empty
                        count_s = 4'd0;
                    end else begin
                        display_s = shifted_s;
                        count_s   = count_r + 4'd1;
                        if ((AUTO_COMMIT != 0) && (count_r == ND_LAST_C)) begin
                            state_s    = ST_COMMIT;
                            op_valid_s = 1'b1;
                            op_value_s = shifted_s;
                        end else begin
                            state_s = ST_ENTRY;
                        end
                    end
                end else begin
                    case (key_code)
                        4'hA: begin
                            if (count_r != 4'd0) begin
                                display_s = display_r >> 3'd4;
                                count_s   = count_r - 4'd1;
                            end else begin
                                count_s = 4'd0;
                            end
                        end
                        4'hB: begin
                            display_s = '0;
                            count_s   = 4'd0;
                        end
                        4'hC: begin
                            if (count_r != 4'd0) begin
                                state_s    = ST_COMMIT;
                                op_valid_s = 1'b1;
                                op_value_s = display_r;
                            end else begin
                                state_s = ST_ENTRY;
                            end
                        end
                        default: state_s = ST_ENTRY;
                    endcase
                end
            end
            ST_COMMIT: begin
                display_s = '0;
                count_s   = 4'd0;
                if (op_index_r < OP_LAST_C) begin
                    op_index_s = op_index_r + 2'd1;
                    state_s    = ST_ENTRY;
                end else begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end
            end
            ST_DONE: begin
                state_s    = ST_IDLE;
                op_index_s = 2'd0;
            end
            default: begin
                state_s    = ST_IDLE;
                display_s  = '0;
                count_s    = 4'd0;
                op_index_s = 2'd0;
            end
        endcase
    end

    // State and output registers; key_prev tracks the strobe in every state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            key_prev_r <= 1'b0;
            display_r  <= '0;
            count_r    <= 4'd0;
            op_index_r <= 2'd0;
            op_value_r <= '0;
            op_valid_r <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            key_prev_r <= key_pressed;
            display_r  <= display_s;
            count_r    <= count_s;
            op_index_r <= op_index_s;
            op_value_r <= op_value_s;
            op_valid_r <= op_valid_s;
            done_r     <= done_s;
            overflow_r <= overflow_s;
            busy_r     <= (state_s != ST_IDLE);
        end
    end

    assign busy         = busy_r;
    assign display      = display_r;
    assign digit_count  = count_r;
    assign op_index     = op_index_r;
    assign op_valid     = op_valid_r;
    assign op_value     = op_value_r;
    assign done         = done_r;
    assign overflow_err = overflow_r;

endmodule
